// File: rtl/seg7_serial_driver.sv
// N-digit hex 7-segment driver feeding an external shift-register chain.
// Each refresh shifts 8*N active-low bits MSB first, then pulses sload.
module seg7_serial_driver #(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_DIV    = 2,
    parameter int BLINK_BITS = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [4*NUM_DIGITS-1:0] hex,
    input  logic [NUM_DIGITS-1:0]   point,
    input  logic [NUM_DIGITS-1:0]   le,
    input  logic [NUM_DIGITS-1:0]   blink,
    output logic                    busy,
    output logic                    done,
    output logic                    sclk,
    output logic                    sdat,
    output logic                    sload
);

    localparam int W  = 8 * NUM_DIGITS;
    localparam int BW = $clog2(W);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] LATCH = 2'd2;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);

    function automatic logic [6:0] seg_code(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [1:0]            state;
    logic [DW-1:0]         div;
    logic [BW-1:0]         bitn;
    logic [W-2:0]          sr;
    logic [BLINK_BITS-1:0] bcnt;
    logic [W-1:0]          pattern;
    logic                  phase;

    assign phase = bcnt[BLINK_BITS-1];

    always_comb begin
        pattern = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (le[i] || (blink[i] && !phase))
                pattern[8*i +: 8] = 8'hFF;
            else
                pattern[8*i +: 8] = {~point[i], seg_code(hex[4*i +: 4])};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bcnt <= '0;
        else
            bcnt <= bcnt + BLINK_BITS'(1);
    end

    // sdat holds the bit on the wire; sr holds the bits still to go.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            div   <= '0;
            bitn  <= '0;
            sr    <= '1;
            busy  <= 1'b0;
            done  <= 1'b0;
            sclk  <= 1'b0;
            sdat  <= 1'b0;
            sload <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sr    <= pattern[W-2:0];
                        sdat  <= pattern[W-1];
                        sclk  <= 1'b0;
                        busy  <= 1'b1;
                        div   <= '0;
                        bitn  <= BIT_LAST;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (div != DIV_LAST) begin
                        div <= div + DW'(1);
                    end else begin
                        div <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else if (bitn == '0) begin
                            sclk  <= 1'b0;
                            sdat  <= 1'b0;
                            sload <= 1'b1;
                            state <= LATCH;
                        end else begin
                            sclk <= 1'b0;
                            sdat <= sr[W-2];
                            sr   <= {sr[W-3:0], 1'b1};
                            bitn <= bitn - BW'(1);
                        end
                    end
                end
                LATCH: begin
                    if (div != DIV_LAST) begin
                        div <= div + DW'(1);
                    end else begin
                        div   <= '0;
                        sload <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_serial_driver.sv
// Scoreboard bench for seg7_serial_driver: frames captured on sclk rises
// are compared with a reference pattern queued when each start is issued.
module tb_seg7_serial_driver;

    localparam int N  = 8;
    localparam int CD = 2;
    localparam int BB = 4;
    localparam int BUSY_LEN = 16 * N * CD + CD;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [4*N-1:0] hex = '0;
    logic [N-1:0]  point = '0;
    logic [N-1:0]  le = '0;
    logic [N-1:0]  blink = '0;
    logic          busy, done, sclk, sdat, sload;

    int checks = 0;
    int passes = 0;

    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    int          nb_q[$];

    logic [BB-1:0] mcnt;
    logic          psclk = 1'b0;
    logic          psload = 1'b0;
    logic [63:0]   cap = '0;
    int            nbits = 0;
    int            busy_tot = 0;
    int            sload_tot = 0;
    int            done_tot = 0;

    seg7_serial_driver #(
        .NUM_DIGITS(N),
        .CLK_DIV(CD),
        .BLINK_BITS(BB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .hex(hex),
        .point(point),
        .le(le),
        .blink(blink),
        .busy(busy),
        .done(done),
        .sclk(sclk),
        .sdat(sdat),
        .sload(sload)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) mcnt <= '0;
        else     mcnt <= mcnt + 1'b1;
    end

    always @(negedge clk) begin
        if (rst) begin
            nbits = 0;
            cap = '0;
        end else begin
            if (sclk && !psclk) begin
                cap = {cap[62:0], sdat};
                nbits++;
            end
            if (sload && !psload) begin
                got_q.push_back(cap);
                nb_q.push_back(nbits);
                nbits = 0;
            end
        end
        psclk = sclk;
        psload = sload;
        if (busy)  busy_tot++;
        if (sload) sload_tot++;
        if (done)  done_tot++;
    end

    function automatic logic [6:0] segc(input logic [3:0] n);
        logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                               7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                               7'h46, 7'h21, 7'h06, 7'h0E};
        return t[n];
    endfunction

    function automatic logic [63:0] model(input logic [31:0] h,
                                          input logic [7:0] p,
                                          input logic [7:0] l,
                                          input logic [7:0] b,
                                          input logic ph);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (l[i] || (b[i] && !ph)) r[8*i +: 8] = 8'hFF;
            else r[8*i +: 8] = {~p[i], segc(h[4*i +: 4])};
        end
        return r;
    endfunction

    // Call at a negedge; start is sampled at the following posedge.
    task automatic launch(input logic [31:0] h, input logic [7:0] p,
                          input logic [7:0] l, input logic [7:0] b);
        hex = h;
        point = p;
        le = l;
        blink = b;
        exp_q.push_back(model(h, p, l, b, mcnt[BB-1]));
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output bit to);
        to = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        exp_q.delete();
        got_q.delete();
        nb_q.delete();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
        else passes++;
        checks++;
        if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done);
        else passes++;
        checks++;
        if (sclk !== 1'b0) $display("FAIL reset_sclk got %b want 0", sclk);
        else passes++;
        checks++;
        if (sdat !== 1'b0) $display("FAIL reset_sdat got %b want 0", sdat);
        else passes++;
        checks++;
        if (sload !== 1'b0) $display("FAIL reset_sload got %b want 0", sload);
        else passes++;
    endtask

    task automatic test_basic;
        int b0, s0, d0, nb;
        bit to;
        logic [63:0] g, e;
        b0 = busy_tot; s0 = sload_tot; d0 = done_tot;
        @(negedge clk);
        launch(32'h01234567, 8'h00, 8'h00, 8'h00);
        wait_done(to);
        repeat (2) @(negedge clk);
        checks++;
        if (to) $display("FAIL basic_timeout got no done want done");
        else passes++;
        checks++;
        if (got_q.size() == 0 || exp_q.size() == 0) begin
            $display("FAIL basic_frame got no frame want one");
        end else begin
            g = got_q.pop_front(); e = exp_q.pop_front(); nb = nb_q.pop_front();
            if (g !== e) $display("FAIL basic_frame got %h want %h", g, e);
            else passes++;
            checks++;
            if (g !== 64'hC0F9A4B0999282F8)
                $display("FAIL basic_literal got %h want C0F9A4B0999282F8", g);
            else passes++;
            checks++;
            if (nb !== 64) $display("FAIL basic_bits got %0d want 64", nb);
            else passes++;
        end
        checks++;
        if (busy_tot - b0 !== BUSY_LEN)
            $display("FAIL basic_busy got %0d want %0d", busy_tot - b0, BUSY_LEN);
        else passes++;
        checks++;
        if (sload_tot - s0 !== CD)
            $display("FAIL basic_sload got %0d want %0d", sload_tot - s0, CD);
        else passes++;
        checks++;
        if (done_tot - d0 !== 1)
            $display("FAIL basic_done got %0d want 1", done_tot - d0);
        else passes++;
    endtask

    task automatic test_point_le;
        bit to;
        logic [63:0] g, e;
        @(negedge clk);
        launch(32'h01234567, 8'h01, 8'h80, 8'h00);
        wait_done(to);
        repeat (2) @(negedge clk);
        checks++;
        if (to || got_q.size() == 0 || exp_q.size() == 0) begin
            $display("FAIL ptle_frame got no frame want one");
        end else begin
            g = got_q.pop_front(); e = exp_q.pop_front(); void'(nb_q.pop_front());
            if (g !== e) $display("FAIL ptle_frame got %h want %h", g, e);
            else passes++;
            checks++;
            if (g !== 64'hFFF9A4B099928278)
                $display("FAIL ptle_literal got %h want FFF9A4B099928278", g);
            else passes++;
        end
    endtask

    task automatic test_blink;
        bit to;
        logic [63:0] g, e;
        logic [63:0] lit [2] = '{64'hFFFFFFFFFFFFFFFF, 64'hC0F9A4B0999282F8};
        logic [BB-1:0] at [2] = '{4'd3, 4'd9};
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (mcnt == at[k]) break;
            end
            checks++;
            if (mcnt !== at[k]) $display("FAIL blink_sync got %0d want %0d", mcnt, at[k]);
            else passes++;
            launch(32'h01234567, 8'h00, 8'h00, 8'hFF);
            wait_done(to);
            repeat (2) @(negedge clk);
            checks++;
            if (to || got_q.size() == 0 || exp_q.size() == 0) begin
                $display("FAIL blink_frame%0d got no frame want one", k);
            end else begin
                g = got_q.pop_front(); e = exp_q.pop_front(); void'(nb_q.pop_front());
                if (g !== e) $display("FAIL blink_frame%0d got %h want %h", k, g, e);
                else passes++;
                checks++;
                if (g !== lit[k]) $display("FAIL blink_literal%0d got %h want %h", k, g, lit[k]);
                else passes++;
            end
        end
        blink = '0;
    endtask

    task automatic test_busy_ignore;
        int b0, d0;
        bit to;
        logic [63:0] g, e;
        b0 = busy_tot; d0 = done_tot;
        @(negedge clk);
        launch(32'hFEDCBA98, 8'h3C, 8'h00, 8'h00);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            hex = $urandom;
            point = $urandom;
            start = (i % 2 == 0);
        end
        start = 1'b0;
        wait_done(to);
        repeat (20) @(negedge clk);
        checks++;
        if (done_tot - d0 !== 1) $display("FAIL ignore_done got %0d want 1", done_tot - d0);
        else passes++;
        checks++;
        if (busy_tot - b0 !== BUSY_LEN)
            $display("FAIL ignore_busy got %0d want %0d", busy_tot - b0, BUSY_LEN);
        else passes++;
        checks++;
        if (to || got_q.size() != 1 || exp_q.size() == 0) begin
            $display("FAIL ignore_frame got %0d frames want 1", got_q.size());
            got_q.delete(); exp_q.delete(); nb_q.delete();
        end else begin
            g = got_q.pop_front(); e = exp_q.pop_front(); void'(nb_q.pop_front());
            if (g !== e) $display("FAIL ignore_frame got %h want %h", g, e);
            else passes++;
        end
    endtask

    task automatic test_back_to_back;
        int cyc, low, dn;
        logic [63:0] g, e;
        cyc = 0; low = 0; dn = 0;
        @(negedge clk);
        launch(32'h13579BDF, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 1200 && dn < 2; i++) begin
            @(negedge clk);
            cyc++;
            if (!busy) low++;
            if (done) begin
                dn++;
                if (dn == 1) launch(32'h02468ACE, 8'hF0, 8'h00, 8'h00);
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (dn !== 2) $display("FAIL b2b_dones got %0d want 2", dn);
        else passes++;
        checks++;
        if (cyc !== 2 * (BUSY_LEN + 1)) $display("FAIL b2b_cycles got %0d want %0d", cyc, 2 * (BUSY_LEN + 1));
        else passes++;
        checks++;
        if (low !== 2) $display("FAIL b2b_busy_low got %0d want 2", low);
        else passes++;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (got_q.size() == 0 || exp_q.size() == 0) begin
                $display("FAIL b2b_frame%0d got no frame want one", k);
            end else begin
                g = got_q.pop_front(); e = exp_q.pop_front(); void'(nb_q.pop_front());
                if (g !== e) $display("FAIL b2b_frame%0d got %h want %h", k, g, e);
                else passes++;
            end
        end
    endtask

    task automatic test_reset_mid;
        bit to;
        logic [63:0] g, e;
        @(negedge clk);
        launch(32'h89ABCDEF, 8'h00, 8'h00, 8'h00);
        repeat (100) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            if (sclk) break;
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({sclk, sdat, sload, busy, done} !== 5'b0)
            $display("FAIL midrst_outputs got %b want 00000", {sclk, sdat, sload, busy, done});
        else passes++;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        exp_q.delete(); got_q.delete(); nb_q.delete();
        @(negedge clk);
        launch(32'h89ABCDEF, 8'hA5, 8'h00, 8'h00);
        wait_done(to);
        repeat (2) @(negedge clk);
        checks++;
        if (to || got_q.size() == 0 || exp_q.size() == 0) begin
            $display("FAIL midrst_frame got no frame want one");
        end else begin
            g = got_q.pop_front(); e = exp_q.pop_front(); void'(nb_q.pop_front());
            if (g !== e) $display("FAIL midrst_frame got %h want %h", g, e);
            else passes++;
            checks++;
            if (g !== 64'h00900883C621860E)
                $display("FAIL midrst_literal got %h want 00900883C621860E", g);
            else passes++;
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_point_le;
        test_blink;
        test_busy_ignore;
        test_back_to_back;
        test_reset_mid;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
